// File: rtl/flit_rr_arbiter.sv
// Round-robin flit arbiter with packet locking and a one-cycle registered output stage.
// Optional per-requester completed-packet counters are enabled by defining FLIT_ARB_CNT_EN.
module flit_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_DW = 512,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*FLIT_DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_eop,
    output logic [NUM_REQ-1:0]         req_gnt,
    input  logic                       out_rdy,
    output logic [FLIT_DW-1:0]         out_data,
    output logic                       out_vld,
    output logic                       out_eop
`ifdef FLIT_ARB_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]   gnt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] cand;
    logic             gnt_any;
    logic             xfer;
    logic             xfer_eop;
    logic [FLIT_DW-1:0] out_data_q;
    logic             out_vld_q, out_eop_q;

    // A locked owner is granted even without a valid flit so the lock survives bubbles.
    always_comb begin
        gnt_any = 1'b0;
        gidx    = owner_q;
        cand    = '0;
        req_gnt = '0;
        if (out_rdy) begin
            if (state_q == LOCKED) begin
                gnt_any = 1'b1;
                gidx    = owner_q;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (!gnt_any && req_vld[cand]) begin
                        gnt_any = 1'b1;
                        gidx    = cand;
                    end
                end
            end
        end
        if (gnt_any) req_gnt[gidx] = 1'b1;
    end

    assign xfer     = gnt_any & req_vld[gidx];
    assign xfer_eop = xfer & req_eop[gidx];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (req_eop[gidx]) begin
                state_d  = IDLE;
                rr_ptr_d = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end else begin
                state_d = LOCKED;
                owner_d = gidx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            out_eop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            out_vld_q <= xfer;
            out_eop_q <= xfer_eop;
        end
    end

    // Wide data path carries no reset; only loaded when a flit actually moves.
    always_ff @(posedge clk) begin
        if (xfer) out_data_q <= req_data[int'(gidx)*FLIT_DW +: FLIT_DW];
    end

    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;
    assign out_eop  = out_eop_q;

`ifdef FLIT_ARB_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer_eop && (cnt_q[gidx] != {CNT_W{1'b1}})) begin
            cnt_q[gidx] <= cnt_q[gidx] + 1'b1;
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: doc/flit_rr_arbiter.md
FLIT_RR_ARBITER -- requirements
Module: flit_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of flit requesters, range 2..16.
REQ-002 The block SHALL have parameter FLIT_DW, default 512: flit data width.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of each packet-grant counter.
REQ-004 The block SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_vld  input  NUM_REQ  per-requester flit valid.
REQ-007 The block SHALL have port req_data  input  NUM_REQ*FLIT_DW  per-requester flit data; requester i occupies bits [i*FLIT_DW +: FLIT_DW].
REQ-008 The block SHALL have port req_eop  input  NUM_REQ  per-requester last-flit-of-packet marker.
REQ-009 The block SHALL have port req_gnt  output  NUM_REQ  combinational one-hot grant.
REQ-010 The block SHALL have port out_rdy  input  1  downstream can accept a flit this cycle.
REQ-011 The block SHALL have port out_data  output  FLIT_DW  registered flit, feeding the shared flit pipeline.
REQ-012 The block SHALL have port out_vld  output  1  registered flit valid.
REQ-013 The block SHALL have port out_eop  output  1  registered end-of-packet.
REQ-014 The block SHALL have port gnt_cnt  output  NUM_REQ*CNT_W  per-requester completed-packet count; present only under FLIT_ARB_CNT_EN.

Function
REQ-015 Transfer from requester i SHALL occur in a cycle where req_vld[i] & req_gnt[i]; req_gnt SHALL be zero whenever out_rdy=0.
REQ-016 State machine SHALL have states IDLE (no packet in flight) and LOCKED (owner mid-packet).
REQ-017 In IDLE with out_rdy=1, grant SHALL go to the first requester with req_vld=1, searching from rr_ptr upward modulo NUM_REQ.
REQ-018 IDLE->LOCKED SHALL occur on a transfer with req_eop=0; owner = granted index.
REQ-019 In LOCKED, req_gnt SHALL equal one-hot(owner) when out_rdy=1, regardless of req_vld[owner]; other requesters SHALL receive no grant.
REQ-020 LOCKED->IDLE SHALL occur on an owner transfer with req_eop=1.
REQ-021 rr_ptr SHALL update to (index+1) mod NUM_REQ only on an eop transfer; single-flit packets (eop on first flit) SHALL never enter LOCKED.
REQ-022 Latency SHALL be 1 cycle: out_vld/out_eop/out_data at edge N+1 reflect the transfer in cycle N; out_vld=0 when no transfer.
REQ-023 out_data SHALL be a non-reset register loaded on each transfer; out_vld and out_eop SHALL be reset registers.
REQ-024 out_eop SHALL be 0 whenever out_vld=0.
REQ-025 out_rdy=0 during LOCKED SHALL hold state and owner; during IDLE it SHALL leave rr_ptr unchanged.
REQ-026 Owner req_vld=0 in LOCKED SHALL produce a bubble (out_vld=0) without releasing the lock.

Reset
REQ-027 Assertion of rst_n=0 SHALL asynchronously force state=IDLE, rr_ptr=0, out_vld=0, out_eop=0, gnt_cnt=0, including mid-packet; the partial packet is abandoned.
REQ-028 out_data SHALL be undefined after reset until the first transfer.

Configuration
REQ-029 With macro FLIT_ARB_CNT_EN defined, gnt_cnt[i] SHALL increment by 1 on each eop transfer from requester i and saturate at 2^CNT_W-1.
REQ-030 Without FLIT_ARB_CNT_EN, port gnt_cnt and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 All 4 req_vld=1, all eop=1, out_rdy=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; out_vld=1 from cycle 2.
REQ-032 Req 1 sends a 3-flit packet (eop on the 3rd flit) while req 2 is valid throughout -> req_gnt=0010 for 3 cycles, then 0100; out_eop=1 only on the 3rd flit.
REQ-033 LOCKED on req 0; req_vld[0]=0 for 2 cycles, req 3 valid -> out_vld=0 for 2 cycles, no grant to 3, lock held.
REQ-034 out_rdy=0 for 3 cycles mid-packet -> req_gnt=0, out_vld=0, and the packet resumes from the same owner when out_rdy=1.
REQ-035 rst_n pulsed low while LOCKED on req 2 -> out_vld=0 immediately; the next grant goes to req 0 if valid.
REQ-036 With FLIT_ARB_CNT_EN and CNT_W=2: 5 single-flit packets from req 0 -> gnt_cnt[0] = 1,2,3,3,3.
